// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: load handshake and serial-side outputs of the PISO serializer
interface piso_shift_tx_if #(parameter int WIDTH = 4);
    localparam int CNT_W = $clog2(WIDTH);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             serial_data_out;
    logic             frame_active;
    logic             word_done;
    logic [CNT_W-1:0] bit_index;
    modport master (
        output load_valid, load_data,
        input  load_ready, serial_data_out, frame_active, word_done, bit_index
    );
    modport slave (
        input  load_valid, load_data,
        output load_ready, serial_data_out, frame_active, word_done, bit_index
    );
endinterface

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: MSB-first parallel-in/serial-out serializer with zero-gap back-to-back words
module piso_shift_tx #(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic reset,
    piso_shift_tx_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last;
    logic             accept;
    assign last = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    assign bus.load_ready = !reset && (state == IDLE || last);
    assign accept = bus.load_valid && bus.load_ready;
    assign bus.serial_data_out = sreg[WIDTH-1];
    assign bus.frame_active = (state == SHIFT);
    assign bus.word_done = last;
    assign bus.bit_index = cnt;
    // next state: load on accept, else shift; clearing the register after the LSB idles the line at 0
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        if (accept) begin
            state_n = SHIFT;
            sreg_n  = bus.load_data;
            cnt_n   = '0;
        end else if (state == SHIFT) begin
            state_n = last ? IDLE : SHIFT;
            sreg_n  = last ? '0 : {sreg[WIDTH-2:0], 1'b0};
            cnt_n   = last ? '0 : cnt + CNT_W'(1);
        end
    end
    // state register with synchronous reset that aborts any word in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: WIDTH=4 and WIDTH=8 serializers checked against a bit-queue line model
module tb_piso_shift_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(4)) b4();
    piso_shift_tx_if #(.WIDTH(8)) b8();
    piso_shift_tx #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
    piso_shift_tx #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));

    int checks = 0;
    int errors = 0;
    int wd[2] = '{4, 8};
    int lq[2][$];
    int wq[2][$];
    int cap[2] = '{0, 0};
    bit acc[2];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int k);
        return !reset && lq[k].size() <= 1;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            int ser, act, dn, idx, rdy, es, ei, ef, ed;
            string p;
            p   = $sformatf("w%0d", wd[k]);
            ser = k ? int'(b8.serial_data_out) : int'(b4.serial_data_out);
            act = k ? int'(b8.frame_active) : int'(b4.frame_active);
            dn  = k ? int'(b8.word_done) : int'(b4.word_done);
            idx = k ? int'(b8.bit_index) : int'(b4.bit_index);
            rdy = k ? int'(b8.load_ready) : int'(b4.load_ready);
            ef  = lq[k].size() > 0 ? 1 : 0;
            es  = ef ? (lq[k][0] & 1) : 0;
            ei  = ef ? (lq[k][0] >> 1) : 0;
            ed  = (ef && ei == wd[k] - 1) ? 1 : 0;
            chk({p, " serial_data_out"}, ser, es);
            chk({p, " frame_active"}, act, ef);
            chk({p, " word_done"}, dn, ed);
            chk({p, " load_ready"}, rdy, int'(exp_ready(k)));
            if (ef) begin
                chk({p, " bit_index"}, idx, ei);
                cap[k] = (ei == 0) ? ser : ((cap[k] << 1) | ser);
                if (ed && wq[k].size() > 0)
                    chk({p, " sipo word"}, cap[k], wq[k].pop_front());
            end
        end
    endtask

    task automatic model_edge(input int d4, input int d8);
        for (int k = 0; k < 2; k++) begin
            int d;
            d = k ? d8 : d4;
            if (reset) begin
                lq[k].delete();
                wq[k].delete();
            end else begin
                if (lq[k].size() > 0) void'(lq[k].pop_front());
                if (acc[k]) begin
                    for (int i = 0; i < wd[k]; i++)
                        lq[k].push_back((i << 1) | ((d >> (wd[k] - 1 - i)) & 1));
                    wq[k].push_back(d);
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int d4, input int d8);
        reset = r;
        b4.load_valid = v;
        b8.load_valid = v;
        b4.load_data = 4'(d4);
        b8.load_data = 8'(d8);
        @(negedge clk);
        check_outputs();
        for (int k = 0; k < 2; k++) acc[k] = v && exp_ready(k);
        @(posedge clk);
        model_edge(d4, d8);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        b4.load_valid = 1'b0;
        b8.load_valid = 1'b0;
        b4.load_data = '0;
        b8.load_data = '0;
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        // single word 1011 on the 4-bit block, A5 on the 8-bit block
        step(1'b0, 1'b1, 4'b1011, 8'hA5);
        idle(10);
        // back-to-back: hold 1011 until the LSB cycle, then present 0110
        step(1'b0, 1'b1, 4'b1011, 8'h3C);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1011, 8'h3C);
        step(1'b0, 1'b1, 4'b0110, 8'h3C);
        idle(12);
        // backpressure: 0001 offered from bit 1 of an in-flight word
        step(1'b0, 1'b1, 4'b1100, 8'hC3);
        step(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b0001, 8'h01);
        idle(10);
        // reset during bit 2 of 1111, then 1010
        step(1'b0, 1'b1, 4'b1111, 8'hFF);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 4'b1010, 8'hAA);
        idle(10);
        // reset and load_valid together
        step(1'b1, 1'b1, 4'b1111, 8'hFF);
        idle(3);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in/serial-out serializer. It sits directly upstream of the shift-left SIPO deserializer and feeds its serial_data_in.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- MSB-first ordering means a downstream shift-left SIPO holds the original word after WIDTH shifts.
- Supports back-to-back words with no idle gap. Reports per-word progress and completion.

Parameters:
- WIDTH, 4, word length in bits. Legal range is 2 and up.
- CNT_W, $clog2(WIDTH), width of the internal bit counter. Derived, not overridden.

Ports:
- clk  input  1  single clock. All state updates on rising edge; downstream SIPO samples on falling edge (half-cycle setup).
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream presents a word on load_data.
- load_data  input  WIDTH  word to serialize. Sampled only on an accepted transfer.
- load_ready  output  1  block can accept a word this cycle.
- serial_data_out  output  1  serial bit stream, MSB first. Connects to the SIPO serial_data_in.
- frame_active  output  1  serial_data_out carries a valid data bit this cycle.
- word_done  output  1  one-cycle pulse coincident with the last bit (LSB) of a word.
- bit_index  output  CNT_W  index of the bit now on serial_data_out. 0 = MSB; only valid while frame_active is high.

Behaviour:
- Reset (synchronous, active-high, sampled at a rising edge):
  - state=IDLE, shift register=0, bit counter=0.
  - serial_data_out=0, frame_active=0, word_done=0, bit_index=0.
  - While reset is high: load_ready=0 and load_valid is ignored.
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight, bit counter cnt = 0..WIDTH-1.
- load_ready is combinational: 1 when (state==IDLE) or (state==SHIFT and cnt==WIDTH-1), and reset=0. Otherwise 0.
- An accept occurs at a rising edge where load_valid and load_ready are both 1.
- IDLE transitions:
  - On accept: shift register <= load_data, cnt <= 0, state <= SHIFT.
  - Otherwise remain in IDLE.
- Latency: the first bit (load_data[WIDTH-1]) appears on serial_data_out in the cycle after the accepting edge.
- Output mapping: serial_data_out = shift register MSB (registered, glitch-free). frame_active = (state==SHIFT). bit_index = cnt.
- SHIFT, cnt < WIDTH-1: shift register <= {reg[WIDTH-2:0],1'b0}, cnt <= cnt+1.
- SHIFT, cnt == WIDTH-1 (last bit on the line):
  - word_done=1 this cycle (combinational from state and cnt).
  - If accept: reload with load_data, cnt <= 0, stay in SHIFT. The next word's MSB follows the previous LSB with zero gap.
  - If no accept: state <= IDLE, shift register <= 0, so serial_data_out returns to 0.
- load_valid during SHIFT with cnt < WIDTH-1: not accepted. Upstream must hold valid and data stable until the accept.
- load_data changes without an accept have no effect.
- No wrap-around: cnt never exceeds WIDTH-1.
- Reset mid-frame: the word is aborted and the block returns to IDLE at that edge. Outputs go to reset values at that edge. No word_done is issued for the aborted word.
- Reset and load_valid in the same cycle: reset wins and the load is discarded.
- Word rate: back-to-back throughput is exactly 1 bit/clock. A word occupies WIDTH cycles.

Test Plan:
- Single word, WIDTH=4:
  - Stimulus: reset 2 cycles, then load 4'b1011 for 1 cycle.
  - Serial output: serial_data_out = 1,0,1,1 on the next 4 cycles; frame_active high for those 4; word_done high on the 4th; then serial_data_out=0.
  - Downstream SIPO: its parallel_data_out reads 4'b1011 after the 4th falling edge.
- Back-to-back:
  - Stimulus: hold load_valid high with 4'b1011, then switch to 4'b0110 when load_ready rises during the LSB cycle.
  - Response: 8 continuous bits 1,0,1,1,0,1,1,0; frame_active never drops; word_done pulses on bits 4 and 8; load_ready high only in IDLE and on cycles 4 and 8.
- Backpressure: assert load_valid with 4'b0001 during bit 1 of a word in flight.
  - load_ready=0 and the word is not accepted until the LSB cycle.
  - The in-flight word is not corrupted.
  - 0001 is then serialized immediately after.
- Reset mid-frame: assert reset during bit 2 of 4'b1111.
  - Next cycle: serial_data_out=0, frame_active=0, no word_done.
  - After reset is released, load 4'b1010 and check output 1,0,1,0.
- Reset priority: reset=1 and load_valid=1 in the same cycle -> no frame starts and load_ready reads 0 during reset.
- Parameter sweep, WIDTH=8:
  - Load 8'hA5 -> bits 1,0,1,0,0,1,0,1; bit_index counts 0..7; word_done on index 7.
